i2c_bus_arbiter: RTL

- Shares one byte-level I2C master engine among NREQ independent requesters.
- Each requester uses the engine's own cyc/stb/we/data request and ack/busy/err/data response interface.
- Round-robin grant per bus transaction (i_cyc ownership). Waits for the engine to finish its STOP before re-granting.
- Evicts owners that hold the bus idle too long. Sits between the I2C command/register front-ends and the single byte engine.

---
 rtl/i2c_arb_pkg.sv | 32 +++
 rtl/i2c_rr_pick.sv | 47 ++++
 rtl/i2c_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C bus arbiter and its round-robin picker.
//   arb_state_t    : arbiter FSM state (IDLE, OWNED, DRAIN, EVICT)
//   NREQ_MAX       : largest supported number of requesters
//   onehot_to_idx  : converts a one-hot grant vector (up to NREQ_MAX bits)
//                    into its binary index
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWNED = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_EVICT = 2'd3
    } arb_state_t;

    // Lowest set bit wins; callers only ever pass a one-hot or zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = NREQ_MAX - 1; i >= 0; i--) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// ---------------------------------------------------------------------------
// i2c_rr_pick
// Combinational round-robin picker. Chooses the first eligible index
// strictly after last_owner, wrapping around, so last_owner itself is
// considered last.
//   eligible   in  NREQ   requesters allowed to win this round
//   last_owner in  IDX_W  index of the most recent winner
//   grant      out NREQ   one-hot winner (zero when nobody is eligible)
//   valid      out 1      a winner was found
// ---------------------------------------------------------------------------
module i2c_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] last_owner,
    output logic [NREQ-1:0]  grant,
    output logic             valid
);

    localparam logic [IDX_W:0] NREQ_W = (IDX_W + 1)'(NREQ);

    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets 1..NREQ from last_owner; one extra bit on the sum lets the
    // wrap be a single conditional subtract, which also handles NREQ values
    // that are not a power of two.
    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        cand_sum = '0;
        cand_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand_sum = {1'b0, last_owner} + (IDX_W + 1)'(off);
            if (cand_sum >= NREQ_W) begin
                cand_sum = cand_sum - NREQ_W;
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!valid && eligible[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one byte-level I2C master engine among NREQ requesters. Ownership is
// granted round-robin per bus transaction (cyc held high), the engine is
// allowed to finish its STOP before anyone else is granted, and an owner that
// sits idle for 2^HOLD_BITS-1 cycles is evicted with an error pulse.
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_cyc/i_stb/i_we        per-requester ownership request, strobe, direction
//   i_data                  per-requester write byte (requester k at [8k+7:8k])
//   o_ack/o_busy/o_err      per-requester byte done, stall, error
//   o_data                  read byte from the engine, valid with o_ack
//   o_ll_*                  request side towards the byte engine
//   i_ll_*                  response side from the byte engine
//   o_grant                 one-hot current or draining owner, zero when idle
// ---------------------------------------------------------------------------
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int HOLD_BITS = 24
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_cyc,
    input  logic [NREQ-1:0]   i_stb,
    input  logic [NREQ-1:0]   i_we,
    input  logic [8*NREQ-1:0] i_data,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_busy,
    output logic [NREQ-1:0]   o_err,
    output logic [7:0]        o_data,
    output logic              o_ll_cyc,
    output logic              o_ll_stb,
    output logic              o_ll_we,
    output logic [7:0]        o_ll_data,
    input  logic              i_ll_ack,
    input  logic              i_ll_busy,
    input  logic              i_ll_err,
    input  logic [7:0]        i_ll_data,
    output logic [NREQ-1:0]   o_grant
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [HOLD_BITS-1:0] HOLD_MAX = '1;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [NREQ-1:0]  grant_q;
    logic [IDX_W-1:0] owner_q;
    logic [HOLD_BITS-1:0] hold_q;
    logic [HOLD_BITS-1:0] hold_next;
    logic             hold_active;
    logic             hold_sat;
    logic [NREQ-1:0]  evicted_q;
    logic [NREQ-1:0]  evict_set;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  pick_grant;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    // Evicted requesters sit out until they drop cyc at least once.
    assign eligible = i_cyc & ~evicted_q;

    i2c_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible   (eligible),
        .last_owner (owner_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    assign pick_idx = IDX_W'(onehot_to_idx(NREQ_MAX'(pick_grant)));

    // owner_q doubles as last_owner: it is only rewritten on a new grant, so
    // while OWNED/DRAIN/EVICT it names the owner and in IDLE it is the
    // round-robin pointer.
    assign hold_active = i_stb[owner_q] | i_ll_ack;

    // Saturating idle counter; reaching all-ones is the eviction trigger.
    always_comb begin
        hold_next = hold_q;
        if (hold_active) begin
            hold_next = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_next = hold_q + HOLD_BITS'(1);
        end
    end

    assign hold_sat = (hold_next == HOLD_MAX);

    assign o_grant = grant_q;
    assign o_data  = i_ll_data;

    // Next-state and output routing. Only the owner ever sees engine
    // responses; everybody else is stalled. The release path is tested before
    // the timeout so a dropping owner never gets an error.
    always_comb begin
        state_next = state;
        evict_set  = '0;
        o_ll_cyc   = 1'b0;
        o_ll_stb   = 1'b0;
        o_ll_we    = 1'b0;
        o_ll_data  = '0;
        o_ack      = '0;
        o_err      = '0;
        o_busy     = '1;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                o_ll_cyc         = i_cyc[owner_q];
                o_ll_stb         = i_stb[owner_q];
                o_ll_we          = i_we[owner_q];
                o_ll_data        = i_data[{owner_q, 3'b000} +: 8];
                o_busy[owner_q]  = i_ll_busy;
                o_ack[owner_q]   = i_ll_ack;
                o_err[owner_q]   = i_ll_err;
                if (!i_cyc[owner_q]) begin
                    state_next = ARB_DRAIN;
                end else if (hold_sat) begin
                    state_next = ARB_EVICT;
                end
            end
            ARB_DRAIN: begin
                o_ack[owner_q] = i_ll_ack;
                o_err[owner_q] = i_ll_err;
                if (!i_ll_busy) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_EVICT: begin
                o_ack[owner_q]     = i_ll_ack;
                o_err[owner_q]     = 1'b1;
                evict_set[owner_q] = 1'b1;
                state_next         = ARB_DRAIN;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, round-robin pointer, idle counter and eviction mask. The pointer
    // resets to NREQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant_q   <= '0;
            owner_q   <= IDX_W'(NREQ - 1);
            hold_q    <= '0;
            evicted_q <= '0;
        end else begin
            evicted_q <= (evicted_q & i_cyc) | evict_set;
            if (state == ARB_IDLE && pick_valid) begin
                grant_q <= pick_grant;
                owner_q <= pick_idx;
                hold_q  <= '0;
            end else if (state == ARB_OWNED) begin
                hold_q <= hold_next;
            end else if (state == ARB_DRAIN && !i_ll_busy) begin
                grant_q <= '0;
            end
        end
    end

endmodule
